// File: rtl/player_motion_ctrl.sv
// Player physics and animation controller: one update per synchronized vsync fall.
// Optional air re-launch enabled by defining DOUBLE_JUMP_EN.
module player_motion_ctrl #(
  parameter int X_START     = 32,
  parameter int X_MIN       = 32,
  parameter int X_MAX       = 576,
  parameter int FLOOR_Y     = 416,
  parameter int CEIL_Y      = 32,
  parameter int X_SPEED     = 2,
  parameter int JUMP_V      = 12,
  parameter int GRAVITY     = 1,
  parameter int MAX_FALL    = 15,
  parameter int ANIM_DIV    = 6,
  parameter int WALK_FRAMES = 6,
  parameter int IDLE_FRAMES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vsync,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic              btn_jump,
  output logic [9:0]        img_x,
  output logic [9:0]        img_y,
  output logic [2:0]        frame_idx,
  output logic              is_moving,
  output logic              face_left,
  output logic              on_ground,
  output logic [1:0]        dbg_state,
  output logic signed [7:0] dbg_vel_y
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WALK = 2'd1;
  localparam logic [1:0] ST_JUMP = 2'd2;
  localparam logic [1:0] ST_FALL = 2'd3;

  localparam logic [7:0]         VEL_LAUNCH = 8'(-JUMP_V);
  localparam logic signed [11:0] FLOOR_S    = 12'(FLOOR_Y);
  localparam logic signed [11:0] CEIL_S     = 12'(CEIL_Y);
  localparam logic signed [8:0]  GRAV_S     = 9'(GRAVITY);
  localparam logic signed [8:0]  MAXF_S     = 9'(MAX_FALL);
  localparam logic [3:0]         ANIM_LAST  = 4'(ANIM_DIV - 1);
  localparam logic [2:0]         WALK_LAST  = 3'(WALK_FRAMES - 1);
  localparam logic [2:0]         IDLE_LAST  = 3'(IDLE_FRAMES - 1);

  logic       vs_meta_q, vs_sync_q, vs_prev_q;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic [2:0] frame_q, frame_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] vel_q, vel_d;
  logic [1:0] state_q, state_d;
  logic       face_q, face_d;
  logic       prev_jump_q, prev_jump_d;
`ifdef DOUBLE_JUMP_EN
  logic       air_used_q, air_used_d;
`endif

  logic              tick, go_left, go_right, has_dir, jmp, air_jump;
  logic [10:0]       x_inc;
  logic [9:0]        x_right, x_left;
  logic signed [11:0] ny;
  logic signed [8:0] vel_g;
  logic [7:0]        vel_next;
  logic [1:0]        ground_nxt;
  logic [2:0]        frame_last;

  always_comb begin
    tick     = vs_prev_q & ~vs_sync_q;
    go_left  = btn_left & ~btn_right;
    go_right = btn_right & ~btn_left;
    has_dir  = go_left | go_right;
    jmp      = btn_jump & ~prev_jump_q;
`ifdef DOUBLE_JUMP_EN
    air_jump = jmp & ~air_used_q;
`else
    air_jump = 1'b0;
`endif
    // Saturate against the walls without ever wrapping the 10-bit position.
    x_inc   = {1'b0, x_q} + 11'(X_SPEED);
    x_right = (x_inc > 11'(X_MAX)) ? 10'(X_MAX) : x_inc[9:0];
    x_left  = ({1'b0, x_q} < 11'(X_MIN) + 11'(X_SPEED)) ? 10'(X_MIN) : x_q - 10'(X_SPEED);
    ny       = $signed({2'b00, y_q}) + $signed({{4{vel_q[7]}}, vel_q});
    vel_g    = $signed({vel_q[7], vel_q}) + GRAV_S;
    vel_next = (vel_g > MAXF_S) ? 8'(MAX_FALL) : vel_g[7:0];
    ground_nxt = has_dir ? ST_WALK : ST_IDLE;
    frame_last = (state_q == ST_WALK) ? WALK_LAST : IDLE_LAST;
  end

  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    frame_d     = frame_q;
    cnt_d       = cnt_q;
    vel_d       = vel_q;
    state_d     = state_q;
    face_d      = face_q;
    prev_jump_d = prev_jump_q;
`ifdef DOUBLE_JUMP_EN
    air_used_d  = air_used_q;
`endif
    if (tick) begin
      prev_jump_d = btn_jump;
      if (go_right)     x_d = x_right;
      else if (go_left) x_d = x_left;
      if (go_left)       face_d = 1'b1;
      else if (go_right) face_d = 1'b0;
      case (state_q)
        ST_IDLE, ST_WALK: begin
          if (jmp) begin
            vel_d   = VEL_LAUNCH;
            state_d = ST_JUMP;
          end else begin
            state_d = ground_nxt;
            if (ground_nxt != state_q) begin
              frame_d = 3'd0;
              cnt_d   = 4'd0;
            end else if (cnt_q == ANIM_LAST) begin
              cnt_d   = 4'd0;
              frame_d = (frame_q == frame_last) ? 3'd0 : frame_q + 3'd1;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        default: begin
          if (air_jump) begin
            vel_d   = VEL_LAUNCH;
            state_d = ST_JUMP;
`ifdef DOUBLE_JUMP_EN
            air_used_d = 1'b1;
`endif
          end else if (ny >= FLOOR_S) begin
            y_d     = 10'(FLOOR_Y);
            vel_d   = 8'd0;
            state_d = ground_nxt;
            frame_d = 3'd0;
            cnt_d   = 4'd0;
`ifdef DOUBLE_JUMP_EN
            air_used_d = 1'b0;
`endif
          end else if (ny < CEIL_S) begin
            y_d     = 10'(CEIL_Y);
            vel_d   = 8'd0;
            state_d = ST_FALL;
          end else begin
            y_d     = ny[9:0];
            vel_d   = vel_next;
            state_d = vel_next[7] ? ST_JUMP : ST_FALL;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_meta_q   <= 1'b1;
      vs_sync_q   <= 1'b1;
      vs_prev_q   <= 1'b1;
      x_q         <= 10'(X_START);
      y_q         <= 10'(FLOOR_Y);
      frame_q     <= 3'd0;
      cnt_q       <= 4'd0;
      vel_q       <= 8'd0;
      state_q     <= ST_IDLE;
      face_q      <= 1'b0;
      prev_jump_q <= 1'b0;
`ifdef DOUBLE_JUMP_EN
      air_used_q  <= 1'b0;
`endif
    end else begin
      vs_meta_q   <= vsync;
      vs_sync_q   <= vs_meta_q;
      vs_prev_q   <= vs_sync_q;
      x_q         <= x_d;
      y_q         <= y_d;
      frame_q     <= frame_d;
      cnt_q       <= cnt_d;
      vel_q       <= vel_d;
      state_q     <= state_d;
      face_q      <= face_d;
      prev_jump_q <= prev_jump_d;
`ifdef DOUBLE_JUMP_EN
      air_used_q  <= air_used_d;
`endif
    end
  end

  assign img_x     = x_q;
  assign img_y     = y_q;
  assign frame_idx = frame_q;
  assign is_moving = (state_q != ST_IDLE);
  assign face_left = face_q;
  assign on_ground = ~state_q[1];
  assign dbg_state = state_q;
  assign dbg_vel_y = vel_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl: table of per-tick vectors plus jump,
// ceiling, vsync-latency and reset sequences; DOUBLE_JUMP_EN selects air-jump expectations.
module tb_player_motion_ctrl;

  logic clk = 1'b0;
  logic rst, vsync, btn_left, btn_right, btn_jump, b40_jump;
  logic [9:0] img_x, img_y, b_img_x, b_img_y;
  logic [2:0] frame_idx, b_frame_idx;
  logic is_moving, face_left, on_ground, b_is_moving, b_face_left, b_on_ground;
  logic [1:0] dbg_state, b_dbg_state;
  logic signed [7:0] dbg_vel_y, b_dbg_vel_y;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  player_motion_ctrl dut (
    .clk(clk), .rst(rst), .vsync(vsync), .btn_left(btn_left), .btn_right(btn_right),
    .btn_jump(btn_jump), .img_x(img_x), .img_y(img_y), .frame_idx(frame_idx),
    .is_moving(is_moving), .face_left(face_left), .on_ground(on_ground),
    .dbg_state(dbg_state), .dbg_vel_y(dbg_vel_y)
  );

  player_motion_ctrl #(.JUMP_V(40)) dut_hi (
    .clk(clk), .rst(rst), .vsync(vsync), .btn_left(1'b0), .btn_right(1'b0),
    .btn_jump(b40_jump), .img_x(b_img_x), .img_y(b_img_y), .frame_idx(b_frame_idx),
    .is_moving(b_is_moving), .face_left(b_face_left), .on_ground(b_on_ground),
    .dbg_state(b_dbg_state), .dbg_vel_y(b_dbg_vel_y)
  );

  typedef struct {
    logic l, r, j;
    int   n;
    int   x, y, f, m, fc, g;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; vsync low across two rising edges, then settle.
  task automatic frame_tick();
    vsync = 1'b0;
    repeat (2) @(negedge clk);
    vsync = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic apply(input logic l, input logic r, input logic j, input int n);
    btn_left = l; btn_right = r; btn_jump = j;
    for (int k = 0; k < n; k++) frame_tick();
  endtask

  task automatic check_reset(input string tag);
    check({tag, " x"}, img_x, 32);
    check({tag, " y"}, img_y, 416);
    check({tag, " frame"}, frame_idx, 0);
    check({tag, " moving"}, is_moving, 0);
    check({tag, " face"}, face_left, 0);
    check({tag, " ground"}, on_ground, 1);
    check({tag, " state"}, dbg_state, 0);
    check({tag, " vel"}, dbg_vel_y, 0);
  endtask

  vec_t vecs[17];
  int   cnt;

  initial begin
    rst = 1'b1; vsync = 1'b1; btn_left = 0; btn_right = 0; btn_jump = 0; b40_jump = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset("reset");

    vecs[0]  = '{0, 0, 0, 5,   32,  416, 0, 0, 0, 1};
    vecs[1]  = '{0, 0, 0, 1,   32,  416, 1, 0, 0, 1};
    vecs[2]  = '{0, 0, 0, 6,   32,  416, 2, 0, 0, 1};
    vecs[3]  = '{0, 0, 0, 6,   32,  416, 3, 0, 0, 1};
    vecs[4]  = '{0, 0, 0, 6,   32,  416, 0, 0, 0, 1};
    vecs[5]  = '{0, 1, 0, 1,   34,  416, 0, 1, 0, 1};
    vecs[6]  = '{0, 1, 0, 5,   44,  416, 0, 1, 0, 1};
    vecs[7]  = '{0, 1, 0, 1,   46,  416, 1, 1, 0, 1};
    vecs[8]  = '{0, 1, 0, 30,  106, 416, 0, 1, 0, 1};
    vecs[9]  = '{0, 1, 0, 270, 576, 416, 3, 1, 0, 1};
    vecs[10] = '{1, 0, 0, 1,   574, 416, 3, 1, 1, 1};
    vecs[11] = '{1, 1, 0, 1,   574, 416, 0, 0, 1, 1};
    vecs[12] = '{1, 1, 0, 6,   574, 416, 1, 0, 1, 1};
    vecs[13] = '{0, 0, 0, 1,   574, 416, 1, 0, 1, 1};
    vecs[14] = '{1, 0, 0, 300, 32,  416, 1, 1, 1, 1};
    vecs[15] = '{0, 1, 0, 1,   34,  416, 2, 1, 0, 1};
    vecs[16] = '{0, 0, 0, 1,   34,  416, 0, 0, 0, 1};

    for (int i = 0; i < 17; i++) begin
      apply(vecs[i].l, vecs[i].r, vecs[i].j, vecs[i].n);
      check($sformatf("vec%0d x", i), img_x, vecs[i].x);
      check($sformatf("vec%0d y", i), img_y, vecs[i].y);
      check($sformatf("vec%0d frame", i), frame_idx, vecs[i].f);
      check($sformatf("vec%0d moving", i), is_moving, vecs[i].m);
      check($sformatf("vec%0d face", i), face_left, vecs[i].fc);
      check($sformatf("vec%0d ground", i), on_ground, vecs[i].g);
    end

    // Single jump pulse: takeoff, apex, landing.
    apply(0, 0, 1, 1);
    check("takeoff y", img_y, 416);
    check("takeoff state", dbg_state, 2);
    check("takeoff ground", on_ground, 0);
    check("takeoff vel", dbg_vel_y, -12);
    apply(0, 0, 0, 11);
    check("air11 y", img_y, 339);
    check("air11 state", dbg_state, 2);
    apply(0, 0, 0, 1);
    check("apex y", img_y, 338);
    check("apex state", dbg_state, 3);
    check("apex vel", dbg_vel_y, 0);
    apply(0, 0, 0, 12);
    check("air24 y", img_y, 404);
    check("air24 ground", on_ground, 0);
    apply(0, 0, 0, 1);
    check("land y", img_y, 416);
    check("land ground", on_ground, 1);
    check("land frame", frame_idx, 0);
    check("land vel", dbg_vel_y, 0);

    // Held jump: one launch only, idle animation resumes from 0 after landing.
    apply(0, 0, 1, 13);
    check("hold apex y", img_y, 338);
    check("hold apex state", dbg_state, 3);
    apply(0, 0, 1, 27);
    check("hold y", img_y, 416);
    check("hold ground", on_ground, 1);
    check("hold frame", frame_idx, 2);
    apply(0, 0, 0, 1);

    // High launch instance: ceiling clamp then fall to floor.
    b40_jump = 1'b1;
    frame_tick();
    b40_jump = 1'b0;
    apply(0, 0, 0, 10);
    check("hi air10 y", b_img_y, 61);
    check("hi air10 vel", b_dbg_vel_y, -30);
    apply(0, 0, 0, 1);
    check("hi ceil y", b_img_y, 32);
    check("hi ceil vel", b_dbg_vel_y, 0);
    check("hi ceil state", b_dbg_state, 3);
    cnt = 0;
    while (!b_on_ground && cnt < 60) begin
      frame_tick();
      cnt++;
    end
    check("hi fall ticks", cnt, 34);
    check("hi land y", b_img_y, 416);

    // Second press at airborne tick 5, third press at tick 7.
    apply(0, 0, 1, 1);
    apply(0, 0, 0, 4);
    check("dj air4 y", img_y, 374);
    apply(0, 0, 1, 1);
`ifdef DOUBLE_JUMP_EN
    check("dj press2 y", img_y, 374);
    check("dj press2 vel", dbg_vel_y, -12);
`else
    check("dj press2 y", img_y, 366);
    check("dj press2 vel", dbg_vel_y, -7);
`endif
    apply(0, 0, 0, 1);
    apply(0, 0, 1, 1);
`ifdef DOUBLE_JUMP_EN
    check("dj press3 y", img_y, 351);
    check("dj press3 vel", dbg_vel_y, -10);
`else
    check("dj press3 y", img_y, 353);
    check("dj press3 vel", dbg_vel_y, -5);
`endif
    btn_jump = 1'b0;
    cnt = 0;
    while (!on_ground && cnt < 60) begin
      frame_tick();
      cnt++;
    end
    check("dj landed", on_ground, 1);
    check("dj land y", img_y, 416);

    // vsync-to-output latency and one tick per fall for a long low pulse.
    btn_right = 1'b1;
    vsync = 1'b0;
    @(negedge clk);
    check("lat clk1 x", img_x, 34);
    @(negedge clk);
    check("lat clk2 x", img_x, 34);
    @(negedge clk);
    check("lat clk3 x", img_x, 36);
    repeat (20) @(negedge clk);
    check("long low x", img_x, 36);
    btn_right = 1'b0;
    vsync = 1'b1;
    repeat (4) @(negedge clk);
    check("between ticks x", img_x, 36);

    // Horizontal motion while airborne, then reset mid-air.
    apply(0, 1, 1, 1);
    apply(0, 1, 0, 2);
    check("air x", img_x, 42);
    check("air y", img_y, 393);
    check("air ground", on_ground, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset("midair rst");
    check("hi rst y", b_img_y, 416);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
